reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised integer register file for the RISC-V core: two combinational read ports, one write port, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for long-latency results (loads, multi-cycle ops). After reset, a built-in clear sequencer zeroes the array one entry per cycle, so no wide reset net is needed on the storage. It replaces the plain register file in the decode/writeback stage.

## Interface

Parameters:
- WIDTH, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >= 2); entry 0 is hardwired zero
- AW, $clog2(DEPTH), address width (derived; do not override)
- BYPASS, 1, 1 = a read of the address being written this cycle returns the write data

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ad1  in  AW  read address 1
- ad2  in  AW  read address 2
- rd1  out  WIDTH  read data 1
- rd2  out  WIDTH  read data 2
- busy1  out  1  scoreboard bit for ad1
- busy2  out  1  scoreboard bit for ad2
- as3  in  AW  write address
- RegWrite  in  1  write enable
- wd3  in  WIDTH  write data
- mark  in  1  set busy bit of mark_addr (producer issued)
- mark_addr  in  AW  register to mark busy
- ready  out  1  1 = clear sequence finished; the file accepts traffic

## Operation

- States: CLEAR and READY. rst_n low forces CLEAR asynchronously: clr_idx = 1, all busy bits = 0, ready = 0.
- CLEAR: each edge writes 0 to registers[clr_idx] and increments clr_idx. The edge that clears DEPTH-1 moves the block to READY. RegWrite and mark are ignored (dropped, never queued). rd1/rd2 = 0, busy1/busy2 = 0.
- READY: writes when RegWrite && as3 != 0; registers[as3] <= wd3 at the edge. Writes to x0 are discarded.
- Reads: rdN = 0 if adN == 0; else wd3 if BYPASS && RegWrite && as3 == adN; else registers[adN].
- Scoreboard (READY only): RegWrite && as3 != 0 clears busy[as3]; mark && mark_addr != 0 sets busy[mark_addr]. On the same address in the same cycle, set wins (newer producer). busy[0] is never set.
- busyN = busy[adN] (registered bit, combinational select). When BYPASS = 1 and a write to adN is in progress in the current cycle, busyN = 0 (the data is available through the bypass). When BYPASS = 0, busyN shows the pre-edge value.
- rst_n asserted mid-operation (in either state): immediate return to CLEAR. The full clear sequence reruns and the contents are zeroed again.

## Timing

- Reset values: ready = 0, busy1 = busy2 = 0, rd1 = rd2 = 0.
- Clear latency: ready rises after exactly DEPTH-1 rising edges with rst_n high (31 for the defaults). The first access is accepted in the cycle ready = 1.
- Read: zero latency (combinational from adN, and from wd3/as3/RegWrite when BYPASS = 1).
- Write: visible through storage one edge later. With BYPASS = 1 it is also visible in the same cycle.
- mark: busy visible on busyN the cycle after the edge.
- No handshake on writes; the producer must hold off until ready = 1.

## Test plan

- Reset release, DEPTH = 32: ready = 0 for 31 edges, then 1. Read all 32 addresses -> all 0, busy all 0.
- READY, write x5 = 0xDEADBEEF, BYPASS = 1: rd1 (ad1 = 5) = 0xDEADBEEF in the same cycle and after. Write x0 = 0x1234 -> rd2 (ad2 = 0) stays 0.
- BYPASS = 0: write x7 = 0xA5A5A5A5 -> rd1 (ad1 = 7) shows the old value (0) in the write cycle and 0xA5A5A5A5 the next cycle.
- mark x3, then busy1 (ad1 = 3) = 1. Later write x3 = 0x42: busy1 = 0 and rd1 = 0x42 (BYPASS = 1). Same-cycle mark and write of x3 -> busy stays 1.
- Write x9 = 0xFF and mark x10, then pulse rst_n low for 1 cycle: ready = 0 immediately and busy = 0. After 31 edges, x9 reads 0 and x10 is not busy. Writes issued during CLEAR are lost.
- Parametrised build, WIDTH = 64, DEPTH = 16: ready after 15 edges. Write x15 = 0xFFFF_FFFF_0000_0001 and read it back intact.

Source files
------------

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write bypass, busy scoreboard and post-reset clear sequencer
module reg_file_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ad1,
  input  logic [AW-1:0]    ad2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic [AW-1:0]    as3,
  input  logic             RegWrite,
  input  logic [WIDTH-1:0] wd3,
  input  logic             mark,
  input  logic [AW-1:0]    mark_addr,
  output logic             ready
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    clr_idx, clr_idx_nx;
  logic [WIDTH-1:0] registers [DEPTH];
  logic [DEPTH-1:0] busy, busy_nx;
  logic             is_ready;
  logic             we;
  logic             mk;

  // Traffic is only honoured once the clear sequence has finished; x0 is never a target.
  assign is_ready = (state == S_READY);
  assign we       = is_ready && RegWrite && (as3 != '0);
  assign mk       = is_ready && mark && (mark_addr != '0);
  assign ready    = is_ready;

  // State and clear-index registers; reset restarts the clear at entry 1 (entry 0 is hardwired).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // Next-state: walk clr_idx up to DEPTH-1, then hand over to normal operation.
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    case (state)
      S_CLEAR: begin
        clr_idx_nx = clr_idx + AW'(1);
        if (clr_idx == AW'(DEPTH - 1)) state_nx = S_READY;
      end
      S_READY: state_nx = S_READY;
      default: state_nx = S_CLEAR;
    endcase
  end

  // Storage has no reset net: it is zeroed by the clear walk, otherwise takes the write port.
  always_ff @(posedge clk) begin
    if (!is_ready) begin
      registers[clr_idx] <= '0;
    end else if (we) begin
      registers[as3] <= wd3;
    end
  end

  // Scoreboard next value: a completing write clears, a new producer sets; set is applied last so it wins.
  always_comb begin
    busy_nx = busy;
    if (we) busy_nx[as3] = 1'b0;
    if (mk) busy_nx[mark_addr] = 1'b1;
  end

  // Scoreboard register; held at zero throughout the clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (is_ready) begin
      busy <= busy_nx;
    end
  end

  // Read port 1: x0 reads zero, in-flight write is forwarded when bypass is enabled.
  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (is_ready && (ad1 != '0)) begin
      if (BYPASS && we && (as3 == ad1)) begin
        rd1   = wd3;
        busy1 = 1'b0;
      end else begin
        rd1   = registers[ad1];
        busy1 = busy[ad1];
      end
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (is_ready && (ad2 != '0)) begin
      if (BYPASS && we && (as3 == ad2)) begin
        rd2   = wd3;
        busy2 = 1'b0;
      end else begin
        rd2   = registers[ad2];
        busy2 = busy[ad2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed table-driven bench for reg_file_sb
module tb_reg_file_sb;

  logic clk;
  logic rst_n;

  // u_a: defaults (bypass on)
  logic [4:0]  ad1_a, ad2_a, as3_a, ma_a;
  logic        we_a, mk_a, b1_a, b2_a, rdy_a;
  logic [31:0] wd3_a, rd1_a, rd2_a;
  // u_b: bypass off
  logic [4:0]  ad1_b, ad2_b, as3_b, ma_b;
  logic        we_b, mk_b, b1_b, b2_b, rdy_b;
  logic [31:0] wd3_b, rd1_b, rd2_b;
  // u_c: 64-bit wide, 16 deep
  logic [3:0]  ad1_c, ad2_c, as3_c, ma_c;
  logic        we_c, mk_c, b1_c, b2_c, rdy_c;
  logic [63:0] wd3_c, rd1_c, rd2_c;

  int passed;
  int total;
  int na, nb, nc;

  reg_file_sb u_a (
    .clk(clk), .rst_n(rst_n), .ad1(ad1_a), .ad2(ad2_a), .rd1(rd1_a), .rd2(rd2_a),
    .busy1(b1_a), .busy2(b2_a), .as3(as3_a), .RegWrite(we_a), .wd3(wd3_a),
    .mark(mk_a), .mark_addr(ma_a), .ready(rdy_a)
  );

  reg_file_sb #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .ad1(ad1_b), .ad2(ad2_b), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(b1_b), .busy2(b2_b), .as3(as3_b), .RegWrite(we_b), .wd3(wd3_b),
    .mark(mk_b), .mark_addr(ma_b), .ready(rdy_b)
  );

  reg_file_sb #(.WIDTH(64), .DEPTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .ad1(ad1_c), .ad2(ad2_c), .rd1(rd1_c), .rd2(rd2_c),
    .busy1(b1_c), .busy2(b2_c), .as3(as3_c), .RegWrite(we_c), .wd3(wd3_c),
    .mark(mk_c), .mark_addr(ma_c), .ready(rdy_c)
  );

  typedef struct {
    logic        we;
    logic [4:0]  as3;
    logic [31:0] wd3;
    logic        mk;
    logic [4:0]  ma;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t vt [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d expected %0d", passed, total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Release reset and count rising edges until each instance reports ready.
  task automatic wait_ready();
    na = 0; nb = 0; nc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rdy_a && na == 0) begin na = n; we_a = 1'b0; mk_a = 1'b0; end
      if (rdy_b && nb == 0) nb = n;
      if (rdy_c && nc == 0) nc = n;
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0;
    {ad1_a, ad2_a, as3_a, ma_a, we_a, mk_a, wd3_a} = '0;
    {ad1_b, ad2_b, as3_b, ma_b, we_b, mk_b, wd3_b} = '0;
    {ad1_c, ad2_c, as3_c, ma_c, we_c, mk_c, wd3_c} = '0;

    //          we    as3    wd3            mk    ma     ad1    ad2    e_rd1          e_rd2          b1    b2
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vt[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        1'b1, 1'b1};
    vt[4]  = '{1'b1, 5'd3,  32'h00000042, 1'b0, 5'd0,  5'd3,  5'd5,  32'h00000042, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd0,  32'h00000042, 32'h0,        1'b0, 1'b0};
    vt[6]  = '{1'b1, 5'd3,  32'h00000077, 1'b1, 5'd3,  5'd3,  5'd0,  32'h00000077, 32'h0,        1'b0, 1'b0};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd0,  32'h00000077, 32'h0,        1'b1, 1'b0};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h00000077, 1'b0, 1'b1};
    vt[10] = '{1'b1, 5'd31, 32'h80000001, 1'b0, 5'd0,  5'd31, 5'd30, 32'h80000001, 32'h0,        1'b0, 1'b0};
    vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd5,  32'h80000001, 32'hDEADBEEF, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    ad1_a = 5'd5; ad2_a = 5'd31;
    #1;
    chk("rst_ready_a", 64'(rdy_a), 64'h0);
    chk("rst_ready_b", 64'(rdy_b), 64'h0);
    chk("rst_ready_c", 64'(rdy_c), 64'h0);
    chk("rst_rd_a", {rd1_a, rd2_a}, 64'h0);
    chk("rst_busy_a", {62'h0, b1_a, b2_a}, 64'h0);

    // Release reset with a write and a mark pending on u_a: both must be dropped during clear
    @(negedge clk);
    rst_n = 1'b1;
    we_a = 1'b1; as3_a = 5'd9; wd3_a = 32'h000000FF; mk_a = 1'b1; ma_a = 5'd10;
    wait_ready();
    chk("clear_edges_a", 64'(na), 64'd31);
    chk("clear_edges_b", 64'(nb), 64'd31);
    chk("clear_edges_c", 64'(nc), 64'd15);
    we_a = 1'b0; mk_a = 1'b0;

    // Every entry zero and not busy after clear
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ad1_a = 5'(i);
      #1;
      chk($sformatf("clear_entry_%0d", i), {31'h0, b1_a, rd1_a}, 64'h0);
    end

    // Table of single-cycle vectors on the bypassing instance
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      we_a = vt[k].we; as3_a = vt[k].as3; wd3_a = vt[k].wd3;
      mk_a = vt[k].mk; ma_a = vt[k].ma; ad1_a = vt[k].ad1; ad2_a = vt[k].ad2;
      #1;
      chk($sformatf("vec%0d_rd1", k), 64'(rd1_a), 64'(vt[k].e_rd1));
      chk($sformatf("vec%0d_rd2", k), 64'(rd2_a), 64'(vt[k].e_rd2));
      chk($sformatf("vec%0d_busy1", k), 64'(b1_a), 64'(vt[k].e_b1));
      chk($sformatf("vec%0d_busy2", k), 64'(b2_a), 64'(vt[k].e_b2));
    end
    @(negedge clk);
    we_a = 1'b0; mk_a = 1'b0;

    // No bypass: old value during write cycle, new value after; busy shows pre-edge value
    we_b = 1'b1; as3_b = 5'd7; wd3_b = 32'hA5A5A5A5; ad1_b = 5'd7;
    #1 chk("nobyp_rd_write_cycle", 64'(rd1_b), 64'h0);
    @(negedge clk);
    we_b = 1'b0;
    #1 chk("nobyp_rd_after", 64'(rd1_b), 64'hA5A5A5A5);
    @(negedge clk);
    mk_b = 1'b1; ma_b = 5'd7;
    #1 chk("nobyp_busy_mark_cycle", 64'(b1_b), 64'h0);
    @(negedge clk);
    mk_b = 1'b0;
    #1 chk("nobyp_busy_after_mark", 64'(b1_b), 64'h1);
    @(negedge clk);
    we_b = 1'b1; wd3_b = 32'h00000001;
    #1;
    chk("nobyp_busy_write_cycle", 64'(b1_b), 64'h1);
    chk("nobyp_rd_write2_cycle", 64'(rd1_b), 64'hA5A5A5A5);
    @(negedge clk);
    we_b = 1'b0;
    #1;
    chk("nobyp_busy_after_write", 64'(b1_b), 64'h0);
    chk("nobyp_rd_after_write2", 64'(rd1_b), 64'h1);

    // Wide build: top entry holds 64 bits intact
    we_c = 1'b1; as3_c = 4'd15; wd3_c = 64'hFFFF_FFFF_0000_0001; ad1_c = 4'd15; ad2_c = 4'd14;
    #1 chk("wide_bypass", rd1_c, 64'hFFFF_FFFF_0000_0001);
    @(negedge clk);
    we_c = 1'b0;
    #1;
    chk("wide_stored", rd1_c, 64'hFFFF_FFFF_0000_0001);
    chk("wide_neighbour", rd2_c, 64'h0);

    // Mid-operation reset: contents and scoreboard wiped, clear reruns
    @(negedge clk);
    we_a = 1'b1; as3_a = 5'd9; wd3_a = 32'h000000FF; mk_a = 1'b1; ma_a = 5'd10;
    ad1_a = 5'd9; ad2_a = 5'd10;
    @(negedge clk);
    we_a = 1'b0; mk_a = 1'b0;
    #1;
    chk("pre_rst_rd9", 64'(rd1_a), 64'hFF);
    chk("pre_rst_busy10", 64'(b2_a), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(rdy_a), 64'h0);
    chk("mid_rst_busy10", 64'(b2_a), 64'h0);
    chk("mid_rst_rd9", 64'(rd1_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    chk("reclear_edges_a", 64'(na), 64'd31);
    @(negedge clk);
    ad1_a = 5'd9; ad2_a = 5'd10;
    #1;
    chk("reclear_rd9", 64'(rd1_a), 64'h0);
    chk("reclear_busy10", 64'(b2_a), 64'h0);
    ad1_a = 5'd5; ad2_a = 5'd3;
    #1;
    chk("reclear_rd5", 64'(rd1_a), 64'h0);
    chk("reclear_busy3", 64'(b2_a), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
